// File: rtl/enemy_shot_pkg.sv
// enemy_shot_pkg
// Shared types and geometry for the enemy bullet controller:
//   state_t   - controller FSM states (S_IDLE, S_RUN, S_DEAD)
//   POS_W     - width of every stored screen coordinate
//   DEF_*     - default playfield / sprite geometry
//   pos_t     - packed x/y screen position
//   spawn_pos - muzzle position below a given enemy cell
package enemy_shot_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DEAD = 2'd2
    } state_t;

    localparam int POS_W = 10;

    localparam int DEF_LINHAS   = 4;
    localparam int DEF_COLUNAS  = 8;
    localparam int DEF_N_SHOTS  = 4;
    localparam int DEF_SPEED    = 4;
    localparam int DEF_ENEMY_W  = 32;
    localparam int DEF_ENEMY_H  = 24;
    localparam int DEF_SCREEN_H = 480;
    localparam int DEF_PLAYER_Y = 440;
    localparam int DEF_PLAYER_W = 32;
    localparam int DEF_PLAYER_H = 16;

    typedef struct packed {
        logic [POS_W-1:0] x;
        logic [POS_W-1:0] y;
    } pos_t;

    // Bullet appears horizontally centred under the shooter's cell, at the
    // bottom edge of that cell. Math is 11 bits wide and truncated on return.
    function automatic pos_t spawn_pos(
        input logic [5:0]       col,
        input logic [5:0]       row,
        input logic [POS_W-1:0] fleet_x,
        input logic [POS_W-1:0] fleet_y,
        input int               enemy_w,
        input int               enemy_h
    );
        pos_t        p;
        logic [10:0] x11;
        logic [10:0] y11;
        x11 = {1'b0, fleet_x} + 11'(col) * 11'(enemy_w) + 11'(enemy_w / 2);
        y11 = {1'b0, fleet_y} + (11'(row) + 11'd1) * 11'(enemy_h);
        p.x = x11[POS_W-1:0];
        p.y = y11[POS_W-1:0];
        return p;
    endfunction

endpackage

// File: rtl/enemy_shot_ctrl_if.sv
// enemy_shot_if
// Bundle between the game engine / formation / renderer side (master) and
// the enemy bullet controller (slave).
//   run, shooter_x/y, enemy_vivos, fleet_x/y, player_x : engine -> controller
//   shot_active, shot_x, shot_y, jogador_vivo           : controller -> engine/renderer
//   lives (only with ENEMY_SHOT_LIVES_EN)               : controller -> engine
interface enemy_shot_if #(
    parameter int LINHAS  = 4,
    parameter int COLUNAS = 8,
    parameter int N_SHOTS = 4
);
    import enemy_shot_pkg::*;

    logic                       run;
    logic [5:0]                 shooter_x;
    logic [5:0]                 shooter_y;
    logic [LINHAS*COLUNAS-1:0]  enemy_vivos;
    logic [POS_W-1:0]           fleet_x;
    logic [POS_W-1:0]           fleet_y;
    logic [POS_W-1:0]           player_x;
    logic [N_SHOTS-1:0]         shot_active;
    logic [POS_W*N_SHOTS-1:0]   shot_x;
    logic [POS_W*N_SHOTS-1:0]   shot_y;
    logic                       jogador_vivo;
`ifdef ENEMY_SHOT_LIVES_EN
    logic [1:0]                 lives;
`endif

    modport master (
        output run, shooter_x, shooter_y, enemy_vivos, fleet_x, fleet_y, player_x,
`ifdef ENEMY_SHOT_LIVES_EN
        input  lives,
`endif
        input  shot_active, shot_x, shot_y, jogador_vivo
    );

    modport slave (
        input  run, shooter_x, shooter_y, enemy_vivos, fleet_x, fleet_y, player_x,
`ifdef ENEMY_SHOT_LIVES_EN
        output lives,
`endif
        output shot_active, shot_x, shot_y, jogador_vivo
    );

endinterface

// File: rtl/enemy_shot_ctrl_shot_slot.sv
// shot_slot
// One enemy bullet: live flag plus x/y position.
//   clk, reset   : clock, synchronous active-high reset
//   i_load       : take i_load_x/i_load_y and go live (wins over step/kill)
//   i_step       : move down by SPEED if live
//   i_kill       : drop the live flag
//   i_player_x   : player box left edge for the hit test
//   o_active/o_x/o_y : registered slot state
//   o_offscreen  : a step this cycle would reach or pass SCREEN_H
//   o_hit        : live bullet currently inside the player box
module shot_slot
    import enemy_shot_pkg::*;
#(
    parameter int SPEED    = DEF_SPEED,
    parameter int SCREEN_H = DEF_SCREEN_H,
    parameter int PLAYER_Y = DEF_PLAYER_Y,
    parameter int PLAYER_W = DEF_PLAYER_W,
    parameter int PLAYER_H = DEF_PLAYER_H
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic             i_step,
    input  logic             i_kill,
    input  logic [POS_W-1:0] i_load_x,
    input  logic [POS_W-1:0] i_load_y,
    input  logic [POS_W-1:0] i_player_x,
    output logic             o_active,
    output logic [POS_W-1:0] o_x,
    output logic [POS_W-1:0] o_y,
    output logic             o_offscreen,
    output logic             o_hit
);
    logic             r_active;
    logic [POS_W-1:0] r_x;
    logic [POS_W-1:0] r_y;
    logic [10:0]      w_y_next;
    logic [10:0]      w_px_end;

    // 11-bit so a bullet near the bottom cannot wrap back to the top
    assign w_y_next    = {1'b0, r_y} + 11'(SPEED);
    assign o_offscreen = r_active && (w_y_next >= 11'(SCREEN_H));

    assign w_px_end = {1'b0, i_player_x} + 11'(PLAYER_W);
    assign o_hit    = r_active
                   && (r_x >= i_player_x) && ({1'b0, r_x} < w_px_end)
                   && ({1'b0, r_y} >= 11'(PLAYER_Y))
                   && ({1'b0, r_y} <  11'(PLAYER_Y + PLAYER_H));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_active <= 1'b0;
            r_x      <= '0;
            r_y      <= '0;
        end else if (i_load) begin
            r_active <= 1'b1;
            r_x      <= i_load_x;
            r_y      <= i_load_y;
        end else begin
            if (i_step && r_active)
                r_y <= w_y_next[POS_W-1:0];
            if (i_kill)
                r_active <= 1'b0;
        end
    end

    assign o_active = r_active;
    assign o_x      = r_x;
    assign o_y      = r_y;

endmodule

// File: rtl/enemy_shot_ctrl.sv
// enemy_shot_ctrl
// Spawns enemy bullets under the engine-selected shooter, moves them down
// the screen and detects hits on the player.
//   clk, reset : clock, synchronous active-high reset
//   bus        : enemy_shot_if slave (engine inputs, shot state, jogador_vivo)
// Build option: ENEMY_SHOT_LIVES_EN gives the player 3 lives, adds bus.lives
// and an invulnerability window after each non-fatal hit.
module enemy_shot_ctrl
    import enemy_shot_pkg::*;
#(
    parameter int          LINHAS      = DEF_LINHAS,
    parameter int          COLUNAS     = DEF_COLUNAS,
    parameter int          N_SHOTS     = DEF_N_SHOTS,
    parameter logic [25:0] FIRE_PERIOD = 26'd2000000,
    parameter logic [19:0] STEP_DIV    = 20'd250000,
    parameter int          SPEED       = DEF_SPEED,
    parameter int          ENEMY_W     = DEF_ENEMY_W,
    parameter int          ENEMY_H     = DEF_ENEMY_H,
    parameter int          SCREEN_H    = DEF_SCREEN_H,
    parameter int          PLAYER_Y    = DEF_PLAYER_Y,
    parameter int          PLAYER_W    = DEF_PLAYER_W,
    parameter int          PLAYER_H    = DEF_PLAYER_H
) (
    input  logic        clk,
    input  logic        reset,
    enemy_shot_if.slave bus
);
    localparam int                   N_ENEMY = LINHAS * COLUNAS;
    localparam logic [N_ENEMY-1:0]   ONE_E   = 1;
    localparam logic [N_SHOTS-1:0]   ONE_S   = 1;

    state_t      r_state;
    logic [25:0] r_fire_cnt;
    logic [19:0] r_step_cnt;
    logic        r_jogador_vivo;

    logic        w_run_st;
    logic        w_fire;
    logic        w_step;
    logic        w_take_hit;
    logic        w_shooter_ok;
    logic        w_spawn_ok;
    logic [5:0]  w_col;
    pos_t        w_spawn;

    logic [N_SHOTS-1:0]            w_active;
    logic [N_SHOTS-1:0]            w_off;
    logic [N_SHOTS-1:0]            w_hit;
    logic [N_SHOTS-1:0]            w_free;
    logic [N_SHOTS-1:0]            w_free_sel;
    logic [N_SHOTS-1:0]            w_load;
    logic [N_SHOTS-1:0]            w_kill;
    logic [N_SHOTS-1:0][POS_W-1:0] w_x;
    logic [N_SHOTS-1:0][POS_W-1:0] w_y;

`ifdef ENEMY_SHOT_LIVES_EN
    localparam logic [21:0] INVUL_CLKS = {STEP_DIV, 2'b00};
    logic [1:0]  r_lives;
    logic [21:0] r_invul;
`endif

    assign w_run_st = (r_state == S_RUN);
    assign w_fire   = w_run_st && (r_fire_cnt == FIRE_PERIOD - 26'd1);
    assign w_step   = w_run_st && (r_step_cnt == STEP_DIV - 20'd1);

`ifdef ENEMY_SHOT_LIVES_EN
    assign w_take_hit = w_run_st && (|w_hit) && (r_invul == '0);
`else
    assign w_take_hit = w_run_st && (|w_hit);
`endif

    // Out-of-range index shifts the one-hot mask off the end, so it reads dead too
    assign w_shooter_ok = ({1'b0, bus.shooter_x} < 7'(N_ENEMY))
                       && (|(bus.enemy_vivos & (ONE_E << bus.shooter_x)));
    assign w_col   = bus.shooter_x - 6'(32'(bus.shooter_y) * COLUNAS);
    assign w_spawn = spawn_pos(w_col, bus.shooter_y, bus.fleet_x, bus.fleet_y,
                               ENEMY_W, ENEMY_H);

    // Free slots are judged on the pre-edge state, so a slot leaving the
    // screen on this edge is not handed out until the next attempt.
    assign w_free     = ~w_active;
    assign w_free_sel = w_free & (~w_free + ONE_S);
    assign w_spawn_ok = w_fire && w_shooter_ok && (|w_free) && !w_take_hit;
    assign w_load     = w_free_sel & {N_SHOTS{w_spawn_ok}};

    // Any accepted hit wipes the whole pool (death, or a lost life)
    assign w_kill = {N_SHOTS{w_take_hit}} | ({N_SHOTS{w_step}} & w_off);

    for (genvar g = 0; g < N_SHOTS; g++) begin : g_slot
        shot_slot #(
            .SPEED    (SPEED),
            .SCREEN_H (SCREEN_H),
            .PLAYER_Y (PLAYER_Y),
            .PLAYER_W (PLAYER_W),
            .PLAYER_H (PLAYER_H)
        ) u_slot (
            .clk         (clk),
            .reset       (reset),
            .i_load      (w_load[g]),
            .i_step      (w_step),
            .i_kill      (w_kill[g]),
            .i_load_x    (w_spawn.x),
            .i_load_y    (w_spawn.y),
            .i_player_x  (bus.player_x),
            .o_active    (w_active[g]),
            .o_x         (w_x[g]),
            .o_y         (w_y[g]),
            .o_offscreen (w_off[g]),
            .o_hit       (w_hit[g])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_fire_cnt     <= '0;
            r_step_cnt     <= '0;
            r_jogador_vivo <= 1'b1;
`ifdef ENEMY_SHOT_LIVES_EN
            r_lives        <= 2'd3;
            r_invul        <= '0;
`endif
        end else begin
`ifdef ENEMY_SHOT_LIVES_EN
            if (r_invul != '0)
                r_invul <= r_invul - 22'd1;
`endif
            case (r_state)
                S_IDLE: begin
                    if (bus.run)
                        r_state <= S_RUN;
                end
                S_RUN: begin
                    r_fire_cnt <= w_fire ? '0 : r_fire_cnt + 26'd1;
                    r_step_cnt <= w_step ? '0 : r_step_cnt + 20'd1;
                    if (w_take_hit) begin
`ifdef ENEMY_SHOT_LIVES_EN
                        r_lives <= r_lives - 2'd1;
                        r_invul <= INVUL_CLKS;
                        if (r_lives == 2'd1) begin
                            r_state        <= S_DEAD;
                            r_jogador_vivo <= 1'b0;
                        end
`else
                        r_state        <= S_DEAD;
                        r_jogador_vivo <= 1'b0;
`endif
                    end else if (!bus.run) begin
                        r_state <= S_IDLE;
                    end
                end
                S_DEAD: ;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.shot_active  = w_active;
    assign bus.shot_x       = w_x;
    assign bus.shot_y       = w_y;
    assign bus.jogador_vivo = r_jogador_vivo;
`ifdef ENEMY_SHOT_LIVES_EN
    assign bus.lives        = r_lives;
`endif

endmodule

// File: tb/tb_enemy_shot_ctrl.sv
module tb_enemy_shot_ctrl;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    enemy_shot_if #(.LINHAS(4), .COLUNAS(8), .N_SHOTS(4)) bus ();

    enemy_shot_ctrl #(
        .FIRE_PERIOD (26'd8),
        .STEP_DIV    (20'd4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        int         slot;
        logic [9:0] x;
        logic [9:0] y;
    } exp_t;

    exp_t sb[$];
    int   vectors  = 0;
    int   miscomp  = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [9:0] get_y(input int s);
        return bus.shot_y[s*10 +: 10];
    endfunction

    function automatic logic [9:0] get_x(input int s);
        return bus.shot_x[s*10 +: 10];
    endfunction

    task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscomp++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Waits for a slot to turn live; returns its index or -1 on timeout.
    task automatic wait_new_active(input int bound, output int slot);
        logic [3:0] prev;
        logic [3:0] nw;
        slot = -1;
        prev = bus.shot_active;
        for (int i = 0; i < bound; i++) begin
            tick();
            nw = bus.shot_active & ~prev;
            if (nw != 4'b0) begin
                for (int k = 3; k >= 0; k--) if (nw[k]) slot = k;
                break;
            end
            prev = bus.shot_active;
        end
    endtask

    task automatic expect_spawn(input string tag);
        int   s;
        exp_t e;
        wait_new_active(40, s);
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 40'(sb.size()), 40'd1);
        end else begin
            e = sb.pop_front();
            chk({tag, "_slot"}, 40'(s), 40'(e.slot));
            if (s >= 0) begin
                chk({tag, "_x"}, 40'(get_x(s)), 40'(e.x));
                chk({tag, "_y"}, 40'(get_y(s)), 40'(e.y));
            end
        end
    endtask

    task automatic wait_y(input int s, input logic [9:0] yv, input int bound, output bit found);
        found = 1'b0;
        for (int i = 0; i < bound; i++) begin
            if (bus.shot_active[s] && get_y(s) == yv) begin
                found = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic push(input int s, input logic [9:0] x, input logic [9:0] y);
        exp_t e;
        e.slot = s; e.x = x; e.y = y;
        sb.push_back(e);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit         found;
        bit         bad;
        logic [9:0] y0;

        reset           = 1'b1;
        bus.run         = 1'b0;
        bus.shooter_x   = 6'd9;
        bus.shooter_y   = 6'd1;
        bus.enemy_vivos = '1;
        bus.fleet_x     = '0;
        bus.fleet_y     = '0;
        bus.player_x    = 10'd300;
        tick();
        tick();
        chk("rst_active", 40'(bus.shot_active), 40'd0);
        chk("rst_x", bus.shot_x, 40'd0);
        chk("rst_y", bus.shot_y, 40'd0);
        chk("rst_vivo", 40'(bus.jogador_vivo), 40'd1);

        // basic spawn below enemy 9 (row 1, col 1)
        reset   = 1'b0;
        bus.run = 1'b1;
        push(0, 10'd48, 10'd48);
        expect_spawn("spawn9");
        tick(); tick(); tick();
        chk("spawn_no_move", 40'(get_y(0)), 40'd48);
        tick();
        chk("first_step", 40'(get_y(0)), 40'd52);

        // dead shooter: three attempts, nothing new
        bus.enemy_vivos[9] = 1'b0;
        bad = 1'b0;
        for (int i = 0; i < 24; i++) begin
            tick();
            if (bus.shot_active != 4'b0001) bad = 1'b1;
        end
        chk("dead_shooter", 40'(bad), 40'd0);

        // fill the pool with varied shooters
        bus.enemy_vivos = '1;
        bus.shooter_x = 6'd0;  bus.shooter_y = 6'd0;
        push(1, 10'd16, 10'd24);
        expect_spawn("spawn0");
        bus.shooter_x = 6'd31; bus.shooter_y = 6'd3;
        push(2, 10'd240, 10'd96);
        expect_spawn("spawn31");
        bus.shooter_x = 6'd20; bus.shooter_y = 6'd2;
        push(3, 10'd144, 10'd72);
        expect_spawn("spawn20");
        for (int i = 0; i < 10; i++) tick();
        chk("pool_full", 40'(bus.shot_active), 40'hF);
        chk("pool_x", bus.shot_x, {10'd144, 10'd240, 10'd16, 10'd48});

        // off-screen exit at exactly SCREEN_H
        bus.enemy_vivos = '0;
        wait_y(0, 10'd476, 1000, found);
        chk("reach_476", 40'(found), 40'd1);
        tick(); tick(); tick();
        chk("alive_at_476", 40'(bus.shot_active[0]), 40'd1);
        tick();
        chk("off_at_480", 40'(bus.shot_active[0]), 40'd0);
        chk("off_vivo", 40'(bus.jogador_vivo), 40'd1);
        for (int i = 0; i < 1000 && bus.shot_active != 4'b0; i++) tick();
        chk("all_off", 40'(bus.shot_active), 40'd0);

        // pause freezes a bullet in place
        bus.shooter_x = 6'd9; bus.shooter_y = 6'd1;
        bus.enemy_vivos[9] = 1'b1;
        push(0, 10'd48, 10'd48);
        expect_spawn("spawn_pause");
        bus.enemy_vivos = '0;
        wait_y(0, 10'd100, 200, found);
        chk("reach_100", 40'(found), 40'd1);
        bus.run = 1'b0;
        bad = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            tick();
            if (get_y(0) != 10'd100 || !bus.shot_active[0]) bad = 1'b1;
        end
        chk("pause_hold", 40'(bad), 40'd0);
        bus.player_x = 10'd16;
        bus.run = 1'b1;
        wait_y(0, 10'd104, 10, found);
        chk("resume_step", 40'(found), 40'd1);

        // player box [16,48) does not cover x=48
        wait_y(0, 10'd452, 1000, found);
        chk("reach_452", 40'(found), 40'd1);
        chk("miss_right_edge", 40'(bus.jogador_vivo), 40'd1);
        for (int i = 0; i < 200 && bus.shot_active != 4'b0; i++) tick();

        // player box [48,80) covers x=48: hit at y=440
        bus.player_x = 10'd48;
        bus.enemy_vivos[9] = 1'b1;
        push(0, 10'd48, 10'd48);
        expect_spawn("spawn_hit");
        bus.enemy_vivos = '0;
        wait_y(0, 10'd440, 1000, found);
        chk("reach_440", 40'(found), 40'd1);
        chk("vivo_before_hit", 40'(bus.jogador_vivo), 40'd1);
        tick();
        chk("vivo_after_hit", 40'(bus.jogador_vivo), 40'd0);
        chk("cleared_on_hit", 40'(bus.shot_active), 40'd0);

        // dead: fire attempts ignored
        bus.enemy_vivos = '1;
        for (int i = 0; i < 30; i++) tick();
        chk("dead_no_fire", 40'(bus.shot_active), 40'd0);
        chk("dead_vivo", 40'(bus.jogador_vivo), 40'd0);

        // reset recovers the player
        reset = 1'b1;
        tick();
        chk("rst2_vivo", 40'(bus.jogador_vivo), 40'd1);
        chk("rst2_active", 40'(bus.shot_active), 40'd0);
        reset = 1'b0;

        // reset mid-flight clears the slot
        bus.player_x = 10'd300;
        push(0, 10'd48, 10'd48);
        expect_spawn("spawn_post_rst");
        reset = 1'b1;
        tick();
        chk("rst_midflight", 40'(bus.shot_active), 40'd0);
        reset = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscomp);
        $finish;
    end

endmodule
